// File: rtl/spi_mem_slave.sv
// SPI responder with a small register-file memory behind it.
// Write frames {data, addr, wr=1} store a word; read frames {addr, wr=0} stream a word back on miso.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for cs low; counter and shift register held clear
// RX_HDR     | shifting in wr flag and address, one bit per clock
// RX_DATA    | shifting in write data
// WRITE      | commit to memory (or flag bad address), pulse op_done
// READ_FETCH | latch memory word (or zero on bad address), pulse ready
// READ_SEND  | drive latched word LSB-first on miso, then drop miso to 0
// WAIT_CS    | frame finished; hold off until cs is seen high
module spi_mem_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic ready,
    output logic op_done,
    output logic addr_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  HDR_LAST   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  SEND_LAST  = CNT_W'(DATA_W);
    localparam logic [ADDR_W:0]   DEPTH_V    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RX_HDR,
        RX_DATA,
        WRITE,
        READ_FETCH,
        READ_SEND,
        WAIT_CS
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [FRAME_W-1:0]   shreg;
    logic [FRAME_W-1:0]   shreg_nxt;
    logic [DATA_W-1:0]    rdata;
    logic [DATA_W-1:0]    rdata_nxt;
    logic                 miso_nxt;
    logic                 ready_nxt;
    logic                 op_done_nxt;
    logic                 addr_err_nxt;
    logic                 mem_we;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic [ADDR_W-1:0]    hdr_addr;
    logic [DATA_W-1:0]    hdr_data;
    logic [IDX_W-1:0]     mem_idx;
    logic                 addr_ok;

    // Frame bits land at their own index, so field positions match the wire order directly.
    assign hdr_addr = shreg[ADDR_W:1];
    assign hdr_data = shreg[FRAME_W-1:ADDR_W+1];
    assign mem_idx  = hdr_addr[IDX_W-1:0];
    assign addr_ok  = ({1'b0, hdr_addr} < DEPTH_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            rdata    <= '0;
            miso     <= 1'b0;
            ready    <= 1'b0;
            op_done  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            rdata    <= rdata_nxt;
            miso     <= miso_nxt;
            ready    <= ready_nxt;
            op_done  <= op_done_nxt;
            addr_err <= addr_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[mem_idx] <= hdr_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        rdata_nxt    = rdata;
        miso_nxt     = 1'b0;
        ready_nxt    = 1'b0;
        op_done_nxt  = 1'b0;
        addr_err_nxt = 1'b0;
        mem_we       = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                shreg_nxt = '0;
                if (!cs) begin
                    state_nxt = RX_HDR;
                end
            end

            RX_HDR: begin
                if (cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end else begin
                    shreg_nxt[cnt] = mosi;
                    cnt_nxt        = cnt + 1'b1;
                    if (cnt == HDR_LAST) begin
                        state_nxt = shreg[0] ? RX_DATA : READ_FETCH;
                    end
                end
            end

            RX_DATA: begin
                if (cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end else begin
                    shreg_nxt[cnt] = mosi;
                    // Hold at the last bit index rather than wrapping.
                    if (cnt == FRAME_LAST) begin
                        state_nxt = WRITE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            WRITE: begin
                op_done_nxt  = 1'b1;
                addr_err_nxt = !addr_ok;
                mem_we       = addr_ok;
                cnt_nxt      = '0;
                state_nxt    = WAIT_CS;
            end

            READ_FETCH: begin
                ready_nxt    = 1'b1;
                addr_err_nxt = !addr_ok;
                rdata_nxt    = addr_ok ? mem[mem_idx] : '0;
                cnt_nxt      = '0;
                state_nxt    = READ_SEND;
            end

            READ_SEND: begin
                if (cnt == SEND_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_CS;
                end else begin
                    miso_nxt  = rdata[0];
                    rdata_nxt = rdata >> 1;
                    cnt_nxt   = cnt + 1'b1;
                end
            end

            WAIT_CS: begin
                if (cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Directed and randomized frames against a word-array model of the slave memory.
// Pulse and miso timing are derived from frame-relative edge numbers.
module tb_spi_mem_slave;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    logic cs;
    logic mosi;
    logic miso;
    logic ready;
    logic op_done;
    logic addr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [DEPTH];

    spi_mem_slave #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .ready    (ready),
        .op_done  (op_done),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
        end
    endtask

    // n counts edges after F (the first edge that sees cs low in IDLE).
    // abort_at/rst_at < 0 disables; hold > 0 keeps cs low that many cycles past the write commit.
    task automatic run_frame(input bit wr, input logic [7:0] a, input logic [7:0] d,
                             input int abort_at, input int hold, input int rst_at);
        logic [16:0] fr;
        logic [7:0]  rd;
        int          nbits;
        int          cs_rise;
        int          last;
        bit          ok_addr;
        bit          aborted;

        fr      = {d, a, wr};
        nbits   = wr ? 17 : 9;
        aborted = (abort_at >= 0);
        ok_addr = (a < DEPTH);
        rd      = ok_addr ? model[a[4:0]] : 8'h00;
        if (aborted)       cs_rise = abort_at;
        else if (hold > 0) cs_rise = 18 + hold;
        else               cs_rise = nbits;
        last = ((cs_rise + 1 > 20) ? cs_rise + 1 : 20) + 1;

        cs   = 1'b0;
        mosi = 1'b0;
        tick();
        for (int n = 0; n <= last; n++) begin
            bit   p_op;
            bit   p_rd;
            logic em;
            p_op = !aborted && wr && (n == 18);
            p_rd = !aborted && !wr && (n == 10);
            em   = (!aborted && !wr && n >= 11 && n <= 18) ? rd[n-11] : 1'b0;
            chk("op_done", {7'd0, op_done}, {7'd0, p_op});
            chk("ready", {7'd0, ready}, {7'd0, p_rd});
            chk("addr_err", {7'd0, addr_err}, {7'd0, (p_op || p_rd) && !ok_addr});
            chk("miso", {7'd0, miso}, {7'd0, em});

            if (n == rst_at) begin
                rst = 1'b0;
                #1;
                chk("async_rst_miso", {7'd0, miso}, 8'h00);
                chk("async_rst_ready", {7'd0, ready}, 8'h00);
                chk("async_rst_op_done", {7'd0, op_done}, 8'h00);
                chk("async_rst_addr_err", {7'd0, addr_err}, 8'h00);
                cs   = 1'b1;
                mosi = 1'b0;
                tick();
                tick();
                rst = 1'b1;
                clear_model();
                tick();
                return;
            end

            if (n >= cs_rise) begin
                cs   = 1'b1;
                mosi = 1'b0;
            end else if (n < nbits) begin
                mosi = fr[n];
            end else begin
                mosi = 1'b0;
            end
            tick();
        end
        if (!aborted && wr && ok_addr) model[a[4:0]] = d;
    endtask

    initial begin
        rst  = 1'b0;
        cs   = 1'b1;
        mosi = 1'b0;
        clear_model();
        #2;
        chk("reset_miso", {7'd0, miso}, 8'h00);
        chk("reset_ready", {7'd0, ready}, 8'h00);
        chk("reset_op_done", {7'd0, op_done}, 8'h00);
        chk("reset_addr_err", {7'd0, addr_err}, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // read after reset, top valid address
        run_frame(1'b0, 8'd31, 8'h00, -1, 0, -1);
        // write then read back
        run_frame(1'b1, 8'd5, 8'hA7, -1, 0, -1);
        run_frame(1'b0, 8'd5, 8'h00, -1, 0, -1);
        // out-of-range address
        run_frame(1'b1, 8'd40, 8'hFF, -1, 0, -1);
        run_frame(1'b0, 8'd40, 8'h00, -1, 0, -1);
        run_frame(1'b0, 8'd8, 8'h00, -1, 0, -1);
        // aborted write followed by a complete one
        run_frame(1'b1, 8'd2, 8'hC3, 6, 0, -1);
        run_frame(1'b1, 8'd2, 8'h3C, -1, 0, -1);
        run_frame(1'b0, 8'd2, 8'h00, -1, 0, -1);
        // cs held low well past the commit: no second op_done, no phantom read
        run_frame(1'b1, 8'd7, 8'h81, -1, 12, -1);
        run_frame(1'b0, 8'd7, 8'h00, -1, 0, -1);
        run_frame(1'b1, 8'd255, 8'h5A, -1, 0, -1);
        run_frame(1'b0, 8'd32, 8'h00, -1, 0, -1);

        for (int it = 0; it < 24; it++) begin
            bit         w;
            logic [7:0] a;
            logic [7:0] d;
            int         ab;
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 39));
            d  = 8'($urandom);
            ab = -1;
            if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, w ? 16 : 8));
            run_frame(w, a, d, ab, 0, -1);
            run_frame(1'b0, a, 8'h00, -1, 0, -1);
        end

        // reset mid-readback clears miso asynchronously
        run_frame(1'b1, 8'd5, 8'hA7, -1, 0, -1);
        run_frame(1'b0, 8'd5, 8'h00, -1, 0, 12);
        // reset during bit 12 of a write: nothing stored
        run_frame(1'b1, 8'd3, 8'h55, -1, 0, 12);
        run_frame(1'b0, 8'd3, 8'h00, -1, 0, -1);
        run_frame(1'b0, 8'd5, 8'h00, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
